// File: rtl/layer_controller.sv
// Time-multiplexes one shared neuron datapath across all weight sets of a layer.
// A per-neuron watchdog aborts the pass if the datapath never answers.
module layer_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_NEURONS = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    output logic                                busy,
    output logic [$clog2(NUM_NEURONS)-1:0]      neuron_select,
    output logic                                neuron_start,
    input  logic                                neuron_done,
    input  logic signed [DATA_WIDTH-1:0]        neuron_out,
    output logic signed [DATA_WIDTH-1:0]        outputs [NUM_NEURONS],
    output logic                                output_ready,
    output logic                                timeout_error
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                       state_reg;
    logic [IDX_W-1:0]             index_reg;
    logic [CNT_W-1:0]             wait_cnt_reg;
    logic                         busy_reg;
    logic                         neuron_start_reg;
    logic                         output_ready_reg;
    logic                         timeout_error_reg;
    logic signed [DATA_WIDTH-1:0] buffer_reg [NUM_NEURONS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            index_reg         <= '0;
            wait_cnt_reg      <= '0;
            busy_reg          <= 1'b0;
            neuron_start_reg  <= 1'b0;
            output_ready_reg  <= 1'b0;
            timeout_error_reg <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                buffer_reg[i] <= '0;
            end
        end else begin
            neuron_start_reg <= 1'b0;
            output_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg         <= ISSUE;
                        index_reg         <= '0;
                        timeout_error_reg <= 1'b0;
                        busy_reg          <= 1'b1;
                        neuron_start_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg    <= WAIT;
                    wait_cnt_reg <= '0;
                end
                WAIT: begin
                    // wait_cnt_reg holds (WAIT cycle number - 1); done on the last cycle still wins
                    if (neuron_done) begin
                        buffer_reg[index_reg] <= neuron_out;
                        if (index_reg == LAST_IDX) begin
                            state_reg        <= DONE;
                            output_ready_reg <= 1'b1;
                        end else begin
                            index_reg        <= index_reg + IDX_W'(1);
                            state_reg        <= ISSUE;
                            neuron_start_reg <= 1'b1;
                        end
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        timeout_error_reg <= 1'b1;
                        busy_reg          <= 1'b0;
                        state_reg         <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_out
        assign outputs[gi] = buffer_reg[gi];
    end

    assign busy          = busy_reg;
    assign neuron_select = index_reg;
    assign neuron_start  = neuron_start_reg;
    assign output_ready  = output_ready_reg;
    assign timeout_error = timeout_error_reg;
endmodule
